// File: rtl/axi_rd_master.sv
// Single-outstanding AXI4 read master: one request in, one AR burst out,
// R beats buffered in a small FIFO and handed back over a valid/ready port.
module axi_rd_master #(
  parameter int unsigned ADDR_W     = 64,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned ID_W       = 4,
  parameter int unsigned AXI_ID     = 0,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [2:0]  PROT       = 3'b100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [7:0]        req_len,
  input  logic [2:0]        req_size,
  input  logic              flush,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [1:0]        rsp_resp,
  output logic              rsp_last,
  output logic              busy,
  output logic              prot_err,
  output logic [ID_W-1:0]   ARID,
  output logic [ADDR_W-1:0] ARADDR,
  output logic [7:0]        ARLEN,
  output logic [2:0]        ARSIZE,
  output logic [1:0]        ARBURST,
  output logic              ARLOCK,
  output logic [3:0]        ARCACHE,
  output logic [2:0]        ARPROT,
  output logic [3:0]        ARQOS,
  output logic [3:0]        ARREGION,
  output logic              ARVALID,
  input  logic              ARREADY,
  input  logic [ID_W-1:0]   RID,
  input  logic [DATA_W-1:0] RDATA,
  input  logic [1:0]        RRESP,
  input  logic              RLAST,
  input  logic              RVALID,
  output logic              RREADY
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_DRAIN} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [1:0]        resp;
    logic              last;
  } beat_t;

  state_t              state_q, state_d;
  logic                pend_q, pend_d;
  logic                arvalid_q, arvalid_d;
  logic [ADDR_W-1:0]   araddr_q, araddr_d;
  logic [7:0]          arlen_q, arlen_d;
  logic [2:0]          arsize_q, arsize_d;
  logic [1:0]          arburst_q, arburst_d;
  logic [2:0]          arprot_q, arprot_d;
  logic [ID_W-1:0]     arid_q, arid_d;
  logic [7:0]          beat_cnt_q, beat_cnt_d;
  logic                prot_err_q, prot_err_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  beat_t               fifo_q [FIFO_DEPTH];

  logic                rready_c;
  logic                req_fire;
  logic                r_hs;
  logic                id_ok;
  logic                beat_last;
  logic                push;
  logic                push_en;
  logic                pop;
  beat_t               push_beat;

  // Next-state, AR field latching, beat accounting and FIFO pointer update
  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    arvalid_d  = arvalid_q;
    araddr_d   = araddr_q;
    arlen_d    = arlen_q;
    arsize_d   = arsize_q;
    arburst_d  = arburst_q;
    arprot_d   = arprot_q;
    arid_d     = arid_q;
    beat_cnt_d = beat_cnt_q;
    prot_err_d = prot_err_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    push       = 1'b0;

    rready_c = 1'b0;
    if (state_q == S_R)     rready_c = (count_q < CNT_W'(FIFO_DEPTH));
    if (state_q == S_DRAIN) rready_c = 1'b1;

    req_fire  = req_valid & (state_q == S_IDLE) & ~flush & ~rst;
    r_hs      = RVALID & rready_c;
    id_ok     = (RID == ID_W'(AXI_ID));
    beat_last = (beat_cnt_q == arlen_q);
    pop       = (count_q != '0) & rsp_ready;
    push_beat = {RDATA, RRESP, RLAST | beat_last};

    case (state_q)
      S_IDLE: begin
        if (req_fire) begin
          araddr_d   = req_addr;
          arlen_d    = req_len;
          arsize_d   = req_size;
          arburst_d  = 2'b01;
          arprot_d   = PROT;
          arid_d     = ID_W'(AXI_ID);
          arvalid_d  = 1'b1;
          beat_cnt_d = 8'd0;
          pend_d     = 1'b0;
          state_d    = S_AR;
        end
      end
      S_AR: begin
        if (flush) pend_d = 1'b1;
        if (ARREADY) begin
          arvalid_d = 1'b0;
          pend_d    = 1'b0;
          state_d   = (pend_q | flush) ? S_DRAIN : S_R;
        end
      end
      S_R: begin
        if (r_hs) begin
          if (id_ok) begin
            push       = 1'b1;
            beat_cnt_d = beat_cnt_q + 8'd1;
            if (RLAST != beat_last) prot_err_d = 1'b1;
            if (RLAST | beat_last)  state_d    = S_IDLE;
          end else begin
            prot_err_d = 1'b1;
          end
        end
        // A beat that completes the burst in the flush cycle leaves nothing to drain
        if (flush && state_d == S_R) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (r_hs) begin
          if (id_ok) begin
            beat_cnt_d = beat_cnt_q + 8'd1;
            if (RLAST | beat_last) state_d = S_IDLE;
          end else begin
            prot_err_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    push_en = push & ~flush;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push_en) - CNT_W'(pop);
    end
  end

  // Control and AR register bank with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pend_q     <= 1'b0;
      arvalid_q  <= 1'b0;
      araddr_q   <= '0;
      arlen_q    <= '0;
      arsize_q   <= '0;
      arburst_q  <= '0;
      arprot_q   <= '0;
      arid_q     <= '0;
      beat_cnt_q <= '0;
      prot_err_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      arvalid_q  <= arvalid_d;
      araddr_q   <= araddr_d;
      arlen_q    <= arlen_d;
      arsize_q   <= arsize_d;
      arburst_q  <= arburst_d;
      arprot_q   <= arprot_d;
      arid_q     <= arid_d;
      beat_cnt_q <= beat_cnt_d;
      prot_err_q <= prot_err_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Response buffer storage; occupancy is tracked by count_q so no reset needed
  always_ff @(posedge clk) begin
    if (push_en) fifo_q[wr_ptr_q] <= push_beat;
  end

  assign req_ready = (state_q == S_IDLE) & ~flush & ~rst;
  assign rsp_valid = (count_q != '0);
  assign rsp_data  = rsp_valid ? fifo_q[rd_ptr_q].data : '0;
  assign rsp_resp  = rsp_valid ? fifo_q[rd_ptr_q].resp : '0;
  assign rsp_last  = rsp_valid & fifo_q[rd_ptr_q].last;
  assign busy      = (state_q != S_IDLE) | rsp_valid;
  assign prot_err  = prot_err_q;
  assign RREADY    = rready_c;

  assign ARID      = arid_q;
  assign ARADDR    = araddr_q;
  assign ARLEN     = arlen_q;
  assign ARSIZE    = arsize_q;
  assign ARBURST   = arburst_q;
  assign ARLOCK    = 1'b0;
  assign ARCACHE   = 4'd0;
  assign ARPROT    = arprot_q;
  assign ARQOS     = 4'd0;
  assign ARREGION  = 4'd0;
  assign ARVALID   = arvalid_q;

endmodule

// File: tb/tb_axi_rd_master.sv
// Directed bench for axi_rd_master: single-beat vector table plus
// hand-written burst, backpressure, flush, protocol-error and reset sequences.
module tb_axi_rd_master;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic [7:0]  req_len;
  logic [2:0]  req_size;
  logic        flush;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_data;
  logic [1:0]  rsp_resp;
  logic        rsp_last;
  logic        busy;
  logic        prot_err;
  logic [3:0]  ARID;
  logic [63:0] ARADDR;
  logic [7:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic        ARLOCK;
  logic [3:0]  ARCACHE;
  logic [2:0]  ARPROT;
  logic [3:0]  ARQOS;
  logic [3:0]  ARREGION;
  logic        ARVALID;
  logic        ARREADY;
  logic [3:0]  RID;
  logic [63:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY;

  int total = 0;
  int bad   = 0;

  axi_rd_master dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_len(req_len), .req_size(req_size), .flush(flush),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_resp(rsp_resp), .rsp_last(rsp_last), .busy(busy), .prot_err(prot_err),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
    .ARBURST(ARBURST), .ARLOCK(ARLOCK), .ARCACHE(ARCACHE), .ARPROT(ARPROT),
    .ARQOS(ARQOS), .ARREGION(ARREGION), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID),
    .RREADY(RREADY)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [63:0] addr;
    logic [2:0]  size;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic [63:0] exp_araddr;
    logic [2:0]  exp_arsize;
    logic [63:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Present a request and check the AR channel the cycle after acceptance
  task automatic do_req(input logic [63:0] addr, input logic [7:0] len, input logic [2:0] size);
    @(negedge clk);
    req_valid = 1'b1; req_addr = addr; req_len = len; req_size = size;
    #1 chk("req_ready", req_ready, 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    chk("arvalid_set", ARVALID, 1'b1);
    chk("araddr", ARADDR, addr);
    chk("arlen", ARLEN, len);
    chk("arsize", ARSIZE, size);
  endtask

  task automatic ar_hs();
    @(negedge clk);
    ARREADY = 1'b1;
    @(negedge clk);
    ARREADY = 1'b0;
    #1 chk("arvalid_clr", ARVALID, 1'b0);
  endtask

  task automatic run_single(input vec_t v);
    do_req(v.addr, 8'd0, v.size);
    chk("sb_araddr", ARADDR, v.exp_araddr);
    chk("sb_arsize", ARSIZE, 64'(v.exp_arsize));
    chk("sb_arprot", ARPROT, 3'b100);
    chk("sb_arburst", ARBURST, 2'b01);
    chk("sb_arid", ARID, 4'd0);
    ar_hs();
    @(negedge clk);
    RVALID = 1'b1; RID = 4'd0; RDATA = v.rdata; RRESP = v.rresp; RLAST = 1'b1;
    #1 chk("sb_rready", RREADY, 1'b1);
    @(negedge clk);
    RVALID = 1'b0; RLAST = 1'b0;
    #1;
    chk("sb_rsp_valid", rsp_valid, 1'b1);
    chk("sb_rsp_data", rsp_data, v.exp_data);
    chk("sb_rsp_resp", rsp_resp, 64'(v.exp_resp));
    chk("sb_rsp_last", rsp_last, 1'b1);
    chk("sb_rready_idle", RREADY, 1'b0);
    chk("sb_req_ready", req_ready, 1'b1);
    @(negedge clk);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    chk("sb_rsp_empty", rsp_valid, 1'b0);
    chk("sb_busy_clr", busy, 1'b0);
  endtask

  initial begin
    int sent;
    int got;
    vec_t v;

    vecs[0] = '{64'h0000_0000_8000_0000, 3'd2, 64'h13, 2'b00,
                64'h0000_0000_8000_0000, 3'd2, 64'h13, 2'b00};
    vecs[1] = '{64'h0000_1000_0000_0040, 3'd3, 64'hDEAD_BEEF_CAFE_F00D, 2'b10,
                64'h0000_1000_0000_0040, 3'd3, 64'hDEAD_BEEF_CAFE_F00D, 2'b10};
    vecs[2] = '{64'hFFFF_FFFF_FFFF_FFF8, 3'd3, 64'h1, 2'b11,
                64'hFFFF_FFFF_FFFF_FFF8, 3'd3, 64'h1, 2'b11};
    vecs[3] = '{64'h4, 3'd0, 64'h0, 2'b01,
                64'h4, 3'd0, 64'h0, 2'b01};

    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_len = '0; req_size = '0;
    flush = 1'b0; rsp_ready = 1'b0; ARREADY = 1'b0; RID = '0; RDATA = '0;
    RRESP = '0; RLAST = 1'b0; RVALID = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_arvalid", ARVALID, 1'b0);
    chk("rst_rready", RREADY, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_prot_err", prot_err, 1'b0);
    chk("rst_araddr", ARADDR, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("post_rst_req_ready", req_ready, 1'b1);

    // Single-beat vector table
    for (int i = 0; i < 4; i++) run_single(vecs[i]);

    // Burst len=7 with response backpressure
    do_req(64'h1000, 8'd7, 3'd3);
    ar_hs();
    sent = 0;
    got  = 0;
    for (int c = 0; c < 60 && got < 8; c++) begin
      @(negedge clk);
      RVALID = (sent < 8); RID = 4'd0; RDATA = 64'(100 + sent); RRESP = 2'b00;
      RLAST = (sent == 7);
      rsp_ready = (c >= 6);
      #1;
      if (c == 5) begin
        chk("bp_rready_low", RREADY, 1'b0);
        chk("bp_sent4", 64'(sent), 64'd4);
      end
      if (RVALID && RREADY) sent++;
      if (rsp_valid && rsp_ready) begin
        chk("bp_data", rsp_data, 64'(100 + got));
        chk("bp_last", rsp_last, (got == 7));
        got++;
      end
    end
    chk("bp_all_delivered", 64'(got), 64'd8);
    @(negedge clk);
    RVALID = 1'b0; RLAST = 1'b0; rsp_ready = 1'b0;
    #1 chk("bp_busy_clr", busy, 1'b0);

    // Late ARREADY with flush while in AR: burst drained
    do_req(64'h2000, 8'd3, 3'd3);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      flush = (c == 2);
      ARREADY = (c == 5);
      #1;
      chk("arflush_arvalid", ARVALID, 1'b1);
      chk("arflush_araddr", ARADDR, 64'h2000);
    end
    @(negedge clk);
    flush = 1'b0; ARREADY = 1'b0;
    #1;
    chk("arflush_arvalid_clr", ARVALID, 1'b0);
    chk("arflush_drain_rready", RREADY, 1'b1);
    chk("arflush_busy", busy, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      RVALID = 1'b1; RDATA = 64'(200 + i); RLAST = (i == 3);
      #1 chk("arflush_no_rsp", rsp_valid, 1'b0);
    end
    @(negedge clk);
    RVALID = 1'b0; RLAST = 1'b0;
    #1;
    chk("arflush_busy_clr", busy, 1'b0);
    chk("arflush_no_rsp_end", rsp_valid, 1'b0);

    // Flush mid-burst with one buffered beat
    do_req(64'h3000, 8'd3, 3'd3);
    ar_hs();
    @(negedge clk);
    RVALID = 1'b1; RDATA = 64'h50; RLAST = 1'b0;
    @(negedge clk);
    RVALID = 1'b0; flush = 1'b1;
    #1 chk("mflush_buffered", rsp_valid, 1'b1);
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("mflush_emptied", rsp_valid, 1'b0);
    chk("mflush_busy", busy, 1'b1);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      RVALID = 1'b1; RDATA = 64'(80 + i); RLAST = (i == 3);
      #1 chk("mflush_rready", RREADY, 1'b1);
    end
    @(negedge clk);
    RVALID = 1'b0; RLAST = 1'b0;
    #1;
    chk("mflush_busy_clr", busy, 1'b0);
    chk("mflush_no_rsp", rsp_valid, 1'b0);
    v = '{64'h3100, 3'd2, 64'h77, 2'b00, 64'h3100, 3'd2, 64'h77, 2'b00};
    run_single(v);

    // Early RLAST on beat 2 of a 4-beat burst
    #1 chk("early_prot_err_pre", prot_err, 1'b0);
    do_req(64'h4000, 8'd3, 3'd3);
    ar_hs();
    @(negedge clk);
    RVALID = 1'b1; RDATA = 64'hA0; RLAST = 1'b0;
    @(negedge clk);
    RDATA = 64'hA1; RLAST = 1'b1;
    @(negedge clk);
    RVALID = 1'b0; RLAST = 1'b0;
    #1;
    chk("early_prot_err", prot_err, 1'b1);
    chk("early_idle_req_ready", req_ready, 1'b1);
    chk("early_rready_low", RREADY, 1'b0);
    chk("early_rsp0_data", rsp_data, 64'hA0);
    chk("early_rsp0_last", rsp_last, 1'b0);
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("early_rsp1_data", rsp_data, 64'hA1);
    chk("early_rsp1_last", rsp_last, 1'b1);
    @(negedge clk);
    rsp_ready = 1'b0;
    #1 chk("early_rsp_empty", rsp_valid, 1'b0);

    // Reset in the middle of a burst
    do_req(64'h5000, 8'd3, 3'd3);
    ar_hs();
    @(negedge clk);
    RVALID = 1'b1; RDATA = 64'h55; RLAST = 1'b0;
    @(negedge clk);
    RVALID = 1'b0; rst = 1'b1;
    @(negedge clk);
    #1;
    chk("mrst_req_ready", req_ready, 1'b0);
    chk("mrst_arvalid", ARVALID, 1'b0);
    chk("mrst_rready", RREADY, 1'b0);
    chk("mrst_rsp_valid", rsp_valid, 1'b0);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_prot_err", prot_err, 1'b0);
    chk("mrst_araddr", ARADDR, 64'h0);
    chk("mrst_arlen", ARLEN, 64'h0);
    chk("mrst_arburst", ARBURST, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("mrst_req_ready_after", req_ready, 1'b1);

    // Foreign RID is dropped and flagged
    do_req(64'h6000, 8'd0, 3'd3);
    ar_hs();
    @(negedge clk);
    RVALID = 1'b1; RID = 4'd5; RDATA = 64'hBAD; RLAST = 1'b1;
    @(negedge clk);
    RID = 4'd0; RDATA = 64'h600D; RLAST = 1'b1;
    #1;
    chk("rid_prot_err", prot_err, 1'b1);
    chk("rid_dropped", rsp_valid, 1'b0);
    chk("rid_still_r", RREADY, 1'b1);
    @(negedge clk);
    RVALID = 1'b0; RLAST = 1'b0;
    #1;
    chk("rid_good_valid", rsp_valid, 1'b1);
    chk("rid_good_data", rsp_data, 64'h600D);
    chk("rid_good_last", rsp_last, 1'b1);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    chk("rid_busy_clr", busy, 1'b0);
    chk("rid_prot_sticky", prot_err, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
